// File: rtl/uart_rx_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_baud_gen
//  Description : UART receive bit-timing generator. A runtime-loadable
//                clocks-per-bit divisor drives a per-bit counter that is
//                re-synchronised by the RX start-bit edge. Per bit it emits
//                an oversample tick, a mid-bit sample strobe and a bit-end
//                strobe. It counts bits per frame and returns to idle after
//                the last bit.
//  Ports       : clk, reset (async, active-high)
//                div_i/div_load    - divisor load (rejected if < 2*OSR)
//                nbits_i           - bits per frame, 0 means 16, latched at start
//                start_i / stop_i  - start-bit edge / abort frame
//                os_tick, sample_tick, bit_end, frame_done - 1-clk strobes
//                bit_idx, busy, div_err - status
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_baud_gen #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned OSR         = 16,
  parameter int unsigned DEFAULT_DIV = 5120
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load,
  input  logic [3:0]       nbits_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             os_tick,
  output logic             sample_tick,
  output logic             bit_end,
  output logic [3:0]       bit_idx,
  output logic             frame_done,
  output logic             busy,
  output logic             div_err
);

  localparam int unsigned      OS_SHIFT  = $clog2(OSR);
  localparam int unsigned      OSI_W     = (OS_SHIFT > 0) ? OS_SHIFT : 1;
  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2 * OSR);
  localparam logic [OSI_W-1:0] OS_LAST   = OSI_W'(OSR - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] os_cnt_q, os_cnt_d;
  logic [OSI_W-1:0] os_idx_q, os_idx_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [3:0]       nbits_q, nbits_d;
  logic [DIV_W-1:0] div_active_q, div_active_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             div_err_q, div_err_d;

  logic             run;
  logic             quiet;
  logic [DIV_W-1:0] os_div;
  logic             bit_last_clk;
  logic             os_hit;
  logic             load_ok;
  logic             apply_slot;

  // Strobes are decoded from registered state. A start or stop pulse
  // suppresses them for that cycle since the bit phase is being discarded.
  assign run          = (state_q == RUN);
  assign quiet        = start_i | stop_i;
  assign os_div       = div_active_q >> OS_SHIFT;
  assign bit_last_clk = run && (cnt_q == div_active_q - 1'b1);

  // The last oversample period of a bit ends on the bit boundary, so any
  // divisor remainder stretches that period instead of adding a short one.
  assign os_hit       = (os_idx_q == OS_LAST) ? bit_last_clk
                                              : (os_cnt_q == os_div - 1'b1);

  assign bit_end      = bit_last_clk && !quiet;
  assign os_tick      = run && !quiet && os_hit;
  assign sample_tick  = run && !quiet && (cnt_q == (div_active_q >> 1));
  assign frame_done   = bit_end && (bit_idx_q == nbits_q - 4'd1);
  assign bit_idx      = bit_idx_q;
  assign busy         = run;
  assign div_err      = div_err_q;

  assign load_ok      = div_load && (div_i >= DIV_MIN);
  // Divisor changes land only where no bit is in progress.
  assign apply_slot   = (state_q == IDLE) || bit_end;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    os_cnt_d     = os_cnt_q;
    os_idx_d     = os_idx_q;
    bit_idx_d    = bit_idx_q;
    nbits_d      = nbits_q;
    div_active_d = div_active_q;
    div_pend_d   = div_pend_q;
    pend_valid_d = pend_valid_q;
    div_err_d    = div_err_q;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        os_cnt_d  = '0;
        os_idx_d  = '0;
        bit_idx_d = 4'd0;
        if (start_i && !stop_i) begin
          state_d = RUN;
          nbits_d = nbits_i;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d   = IDLE;
          cnt_d     = '0;
          os_cnt_d  = '0;
          os_idx_d  = '0;
          bit_idx_d = 4'd0;
        end else if (start_i) begin
          cnt_d     = '0;
          os_cnt_d  = '0;
          os_idx_d  = '0;
          bit_idx_d = 4'd0;
          nbits_d   = nbits_i;
        end else if (bit_end) begin
          cnt_d    = '0;
          os_cnt_d = '0;
          os_idx_d = '0;
          if (frame_done) begin
            state_d   = IDLE;
            bit_idx_d = 4'd0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (os_tick) begin
            os_cnt_d = '0;
            os_idx_d = os_idx_q + 1'b1;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (div_load) begin
      div_err_d = !load_ok;
    end

    if (load_ok) begin
      if (apply_slot) begin
        div_active_d = div_i;
        pend_valid_d = 1'b0;
      end else begin
        div_pend_d   = div_i;
        pend_valid_d = 1'b1;
      end
    end else if (pend_valid_q && apply_slot) begin
      div_active_d = div_pend_q;
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      os_cnt_q     <= '0;
      os_idx_q     <= '0;
      bit_idx_q    <= 4'd0;
      nbits_q      <= 4'd0;
      div_active_q <= DIV_RESET;
      div_pend_q   <= '0;
      pend_valid_q <= 1'b0;
      div_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      os_cnt_q     <= os_cnt_d;
      os_idx_q     <= os_idx_d;
      bit_idx_q    <= bit_idx_d;
      nbits_q      <= nbits_d;
      div_active_q <= div_active_d;
      div_pend_q   <= div_pend_d;
      pend_valid_q <= pend_valid_d;
      div_err_q    <= div_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_baud_gen
//  Description : Directed self-checking bench for uart_rx_baud_gen with
//                default parameters (DIV_W=16, OSR=16, DEFAULT_DIV=5120).
//                Event times are recorded as clock counts after the edge
//                that accepted start_i.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_baud_gen;

  logic        clk;
  logic        reset;
  logic [15:0] div_i;
  logic        div_load;
  logic [3:0]  nbits_i;
  logic        start_i;
  logic        stop_i;
  logic        os_tick;
  logic        sample_tick;
  logic        bit_end;
  logic [3:0]  bit_idx;
  logic        frame_done;
  logic        busy;
  logic        div_err;

  uart_rx_baud_gen #(
    .DIV_W       (16),
    .OSR         (16),
    .DEFAULT_DIV (5120)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .div_i       (div_i),
    .div_load    (div_load),
    .nbits_i     (nbits_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .os_tick     (os_tick),
    .sample_tick (sample_tick),
    .bit_end     (bit_end),
    .bit_idx     (bit_idx),
    .frame_done  (frame_done),
    .busy        (busy),
    .div_err     (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int idle_strobes = 0;
  int q_samp[$];
  int q_be[$];
  int q_os[$];
  int q_fd[$];
  int q_bidx[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_log();
    q_samp.delete();
    q_be.delete();
    q_os.delete();
    q_fd.delete();
    q_bidx.delete();
  endtask

  // One clock: pulses drop after the edge, outputs are sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
    start_i  = 1'b0;
    stop_i   = 1'b0;
    div_load = 1'b0;
    #1;
    cyc++;
    if (os_tick)     q_os.push_back(cyc - t0);
    if (sample_tick) q_samp.push_back(cyc - t0);
    if (frame_done)  q_fd.push_back(cyc - t0);
    if (bit_end) begin
      q_be.push_back(cyc - t0);
      q_bidx.push_back(int'(bit_idx));
    end
    if (!busy && (os_tick || sample_tick || bit_end || frame_done)) idle_strobes++;
  endtask

  task automatic start_frame(input logic [3:0] nb);
    nbits_i = nb;
    start_i = 1'b1;
    step();
    t0 = cyc;
    clear_log();
  endtask

  task automatic load_div(input int d);
    div_i    = 16'(d);
    div_load = 1'b1;
    step();
  endtask

  task automatic run_to_done(input int bound);
    for (int n = 0; n < bound && q_fd.size() == 0; n++) step();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    div_i    = '0;
    div_load = 1'b0;
    nbits_i  = 4'd0;
    start_i  = 1'b0;
    stop_i   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_strobes", int'({os_tick, sample_tick, bit_end, frame_done}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_bit_idx", int'(bit_idx), 0);
    check("rst_div_err", int'(div_err), 0);
    reset = 1'b0;
    step();

    // Full 10-bit frame at the reset divisor
    start_frame(4'd10);
    run_to_done(52000);
    check("f1_sample0", qat(q_samp, 0), 2560);
    check("f1_bitend0", qat(q_be, 0), 5119);
    check("f1_nbitend", q_be.size(), 10);
    check("f1_nsample", q_samp.size(), 10);
    check("f1_done", qat(q_fd, 0), 51199);
    check("f1_ndone", q_fd.size(), 1);
    for (int i = 0; i < 10; i++) check($sformatf("f1_bit_idx%0d", i), qat(q_bidx, i), i);
    check("f1_nos", q_os.size(), 160);
    check("f1_os0", qat(q_os, 0), 319);
    check("f1_os_period", qat(q_os, 1) - qat(q_os, 0), 320);
    check("f1_os_last", qat(q_os, 159), 51199);
    step();
    check("f1_busy_after", int'(busy), 0);
    check("f1_idx_after", int'(bit_idx), 0);

    // Divisor with remainder: last os period stretched
    load_div(5125);
    check("f2_err", int'(div_err), 0);
    start_frame(4'd1);
    run_to_done(6000);
    check("f2_nos", q_os.size(), 16);
    check("f2_os14", qat(q_os, 14), 4799);
    check("f2_os_last_period", qat(q_os, 15) - qat(q_os, 14), 325);
    check("f2_bitend", qat(q_be, 0), 5124);
    check("f2_sample", qat(q_samp, 0), 2562);
    step();

    // Mid-frame load waits for the bit boundary
    load_div(5120);
    start_frame(4'd2);
    repeat (1000) step();
    load_div(5000);
    run_to_done(11000);
    check("f3_bitend0", qat(q_be, 0), 5119);
    check("f3_bitend1", qat(q_be, 1), 10119);
    check("f3_sample0", qat(q_samp, 0), 2560);
    check("f3_sample1", qat(q_samp, 1), 7620);
    check("f3_done", qat(q_fd, 0), 10119);
    step();

    // Minimum legal divisor, then a rejected one
    load_div(64);
    check("f4_err_64", int'(div_err), 0);
    start_frame(4'd2);
    run_to_done(200);
    check("f4_bitend0", qat(q_be, 0), 63);
    check("f4_bitend1", qat(q_be, 1), 127);
    check("f4_sample0", qat(q_samp, 0), 32);
    check("f4_nos", q_os.size(), 32);
    check("f4_os0", qat(q_os, 0), 3);
    step();
    load_div(31);
    check("f4_err_31", int'(div_err), 1);
    start_frame(4'd1);
    run_to_done(200);
    check("f4_div_kept", qat(q_be, 0), 63);
    step();
    load_div(64);
    check("f4_err_clear", int'(div_err), 0);

    // Pending overwrite, and load coinciding with bit_end
    start_frame(4'd3);
    repeat (10) step();
    load_div(100);
    repeat (5) step();
    load_div(80);
    for (int n = 0; n < 400 && q_fd.size() == 0; n++) begin
      step();
      if (bit_end && q_be.size() == 2) begin
        div_i    = 16'd96;
        div_load = 1'b1;
      end
    end
    check("f5_bitend0", qat(q_be, 0), 63);
    check("f5_bitend1", qat(q_be, 1), 143);
    check("f5_bitend2", qat(q_be, 2), 239);
    check("f5_done", qat(q_fd, 0), 239);
    step();

    // Re-synchronisation by start_i in RUN, on a cycle with an os_tick
    load_div(5120);
    start_frame(4'd10);
    repeat (3199) step();
    check("f6_os_pre", int'(os_tick), 1);
    start_i = 1'b1;
    #1;
    check("f6_resync_quiet", int'({os_tick, sample_tick, bit_end}), 0);
    step();
    t0 = cyc;
    clear_log();
    check("f6_idx_resync", int'(bit_idx), 0);
    repeat (2600) step();
    check("f6_sample0", qat(q_samp, 0), 2560);
    check("f6_no_bitend", q_be.size(), 0);
    check("f6_idx", int'(bit_idx), 0);
    stop_i = 1'b1;
    step();
    check("f6_stop_busy", int'(busy), 0);

    // stop_i wins over start_i
    clear_log();
    nbits_i = 4'd4;
    start_i = 1'b1;
    stop_i  = 1'b1;
    step();
    check("f7_busy", int'(busy), 0);
    repeat (20) step();
    check("f7_busy_later", int'(busy), 0);
    check("f7_strobes", q_os.size() + q_samp.size() + q_be.size(), 0);

    // Asynchronous reset mid-frame discards pending divisor
    load_div(2048);
    start_frame(4'd4);
    repeat (3046) step();
    load_div(100);
    load_div(10);
    check("f8_idx_pre", int'(bit_idx), 1);
    check("f8_err_pre", int'(div_err), 1);
    reset = 1'b1;
    #1;
    check("f8_outputs", int'({os_tick, sample_tick, bit_end, frame_done, busy, div_err}), 0);
    check("f8_idx", int'(bit_idx), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_frame(4'd1);
    for (int n = 0; n < 3000 && q_samp.size() == 0; n++) step();
    check("f8_div_default", qat(q_samp, 0), 2560);

    check("idle_strobes", idle_strobes, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
